// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL start-up sequencer / lock supervisor.
package pll_sup_pkg;

    // Supervisor FSM states, in start-up order.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    // Defaults sized for a 50 MHz reference clock.
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_DROP_FILTER   = 4;
    localparam int DEF_CNT_W         = 17;

    // Retry counter saturates here instead of wrapping.
    localparam logic [3:0] RETRY_MAX = 4'd15;

endpackage

// File: rtl/pll_supervisor_if.sv
// Signals between the supervisor and the PLL / core / menu logic.
// master = supervisor side, slave = the environment driving lock and requests.
interface pll_supervisor_if;

    logic       locked;      // PLL lock, asynchronous to clk_sys
    logic       sw_req;      // one-cycle re-init request, clk_sys domain
    logic       pll_rst;     // reset to the PLL
    logic       core_reset;  // reset to the core
    logic       ready;       // high only while running
    logic       lock_lost;   // sticky lock-loss flag
    logic [3:0] retry_cnt;   // saturating lock-timeout retry count

    modport master (
        input  locked, sw_req,
        output pll_rst, core_reset, ready, lock_lost, retry_cnt
    );

    modport slave (
        output locked, sw_req,
        input  pll_rst, core_reset, ready, lock_lost, retry_cnt
    );

endinterface

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous level; output clears on reset.
module sync_ff2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL start-up sequencer and lock supervisor. Runs from the free-running
// reference clock, resets the PLL, waits for lock, holds the core in reset
// until lock has been stable, and re-initialises on a filtered lock loss.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DROP_FILTER   = DEF_DROP_FILTER,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                clk_sys,
    input  logic                rst,
    pll_supervisor_if.master    bus
);

    localparam int DROP_W = $clog2(DROP_FILTER + 1);

    // Terminal counts: the transition happens on the cycle the counter sits here.
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST   = DROP_W'(DROP_FILTER - 1);
    localparam logic [CNT_W-1:0]  TIMER_ONE   = CNT_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE    = DROP_W'(1);

    sup_state_e        state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [3:0]        retry_q, retry_d;
    logic              lost_q, lost_d;
    logic              pll_rst_q, pll_rst_d;
    logic              core_reset_q, core_reset_d;
    logic              ready_q, ready_d;
    logic              locked_s;

    sync_ff2 u_lock_sync (
        .clk_i (clk_sys),
        .rst_i (rst),
        .d_i   (bus.locked),
        .q_o   (locked_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q      <= PLL_RST;
            timer_q      <= '0;
            drop_q       <= '0;
            retry_q      <= '0;
            lost_q       <= 1'b0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            drop_q       <= drop_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = drop_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        if (bus.sw_req) begin
            // Software re-init overrides everything, including a timeout
            // on the same cycle, and does not count as a retry.
            state_d = PLL_RST;
            timer_d = '0;
            drop_d  = '0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = SETTLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        state_d = PLL_RST;
                        timer_d = '0;
                        if (retry_q != RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                        drop_d  = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                RUN: begin
                    if (locked_s) begin
                        drop_d = '0;
                    end else if (drop_q == DROP_LAST) begin
                        state_d = PLL_RST;
                        timer_d = '0;
                        drop_d  = '0;
                        lost_d  = 1'b1;
                    end else begin
                        drop_d = drop_q + DROP_ONE;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    timer_d = '0;
                    drop_d  = '0;
                end
            endcase
        end

        pll_rst_d    = (state_d == PLL_RST);
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.core_reset = core_reset_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lost_q;
    assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor. Stimulus pushes expected output
// snapshots tagged with a cycle number; the monitor pops and compares them
// on the falling edge of that cycle.
module tb_pll_supervisor;

    localparam int T_RST    = 4;
    localparam int T_LOCK   = 20;
    localparam int T_SETTLE = 8;
    localparam int T_DROP   = 3;

    typedef struct {
        int         cyc;
        logic [7:0] val;   // {pll_rst, core_reset, ready, lock_lost, retry_cnt}
        string      name;
    } exp_t;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    pll_supervisor_if bus ();

    pll_supervisor #(
        .RST_CYCLES    (T_RST),
        .LOCK_TIMEOUT  (T_LOCK),
        .SETTLE_CYCLES (T_SETTLE),
        .DROP_FILTER   (T_DROP),
        .CNT_W         (17)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle number = count of rising edges so far.
    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] exp_out(input logic prst, input logic crst,
                                           input logic rdy, input logic lost,
                                           input int rc);
        logic [3:0] r4;
        r4 = rc[3:0];
        return {prst, crst, rdy, lost, r4};
    endfunction

    task automatic expect_at(input int c, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Returns 1 time unit after the rising edge that makes cyc == t.
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset(output int b);
        rst        = 1'b1;
        bus.locked = 1'b0;
        bus.sw_req = 1'b0;
        expect_at(cyc + 2, exp_out(1, 1, 0, 0, 0), "in_reset");
        wait_cyc(cyc + 3);
        rst = 1'b0;
        b   = cyc;
    endtask

    // Scoreboard monitor.
    always @(negedge clk_sys) begin
        logic [7:0] act;
        exp_t       e;
        act = {bus.pll_rst, bus.core_reset, bus.ready, bus.lock_lost, bus.retry_cnt};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d reached late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0d: got pll_rst=%b core_reset=%b ready=%b lock_lost=%b retry_cnt=%0d, expected pll_rst=%b core_reset=%b ready=%b lock_lost=%b retry_cnt=%0d",
                         e.name, cyc, act[7], act[6], act[5], act[4], act[3:0],
                         e.val[7], e.val[6], e.val[5], e.val[4], e.val[3:0]);
            end else begin
                $display("ok   %s @%0d: pll_rst=%b core_reset=%b ready=%b lock_lost=%b retry_cnt=%0d",
                         e.name, cyc, act[7], act[6], act[5], act[4], act[3:0]);
            end
        end
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.locked = 1'b0;
        bus.sw_req = 1'b0;

        // Clean start: lock first sampled at edge 10.
        do_reset(b);
        expect_at(b,      exp_out(1, 1, 0, 0, 0), "clean_c0_pll_rst");
        expect_at(b + 3,  exp_out(1, 1, 0, 0, 0), "clean_c3_pll_rst");
        expect_at(b + 4,  exp_out(0, 1, 0, 0, 0), "clean_c4_wait");
        expect_at(b + 19, exp_out(0, 1, 0, 0, 0), "clean_c19_settle");
        expect_at(b + 20, exp_out(0, 0, 1, 0, 0), "clean_c20_run");
        wait_cyc(b + 9);
        bus.locked = 1'b1;
        wait_cyc(b + 21);

        // Never locks: PLL_RST re-entered every 24 cycles, retry saturates.
        do_reset(b);
        expect_at(b + 23,  exp_out(0, 1, 0, 0, 0),  "nolock_last_wait");
        expect_at(b + 24,  exp_out(1, 1, 0, 0, 1),  "nolock_retry1");
        expect_at(b + 27,  exp_out(1, 1, 0, 0, 1),  "nolock_pulse_end");
        expect_at(b + 28,  exp_out(0, 1, 0, 0, 1),  "nolock_pulse_4cyc");
        expect_at(b + 48,  exp_out(1, 1, 0, 0, 2),  "nolock_retry2");
        expect_at(b + 72,  exp_out(1, 1, 0, 0, 3),  "nolock_retry3");
        expect_at(b + 96,  exp_out(1, 1, 0, 0, 4),  "nolock_retry4");
        expect_at(b + 359, exp_out(0, 1, 0, 0, 14), "nolock_retry14");
        expect_at(b + 360, exp_out(1, 1, 0, 0, 15), "nolock_retry15");
        expect_at(b + 384, exp_out(1, 1, 0, 0, 15), "nolock_sat16");
        expect_at(b + 479, exp_out(0, 1, 0, 0, 15), "nolock_sat_wait");
        expect_at(b + 480, exp_out(1, 1, 0, 0, 15), "nolock_sat20");
        wait_cyc(b + 481);

        // Settle glitch, drop filter, relock, sw_req in RUN and in PLL_RST.
        do_reset(b);
        expect_at(b + 16, exp_out(0, 1, 0, 0, 0), "glitch_settle");
        expect_at(b + 17, exp_out(0, 1, 0, 0, 0), "glitch_seen");
        expect_at(b + 20, exp_out(0, 1, 0, 0, 0), "glitch_no_early_run");
        expect_at(b + 25, exp_out(0, 1, 0, 0, 0), "glitch_pre_run");
        expect_at(b + 26, exp_out(0, 0, 1, 0, 0), "glitch_run");
        expect_at(b + 33, exp_out(0, 0, 1, 0, 0), "drop2_ignored");
        expect_at(b + 36, exp_out(0, 0, 1, 0, 0), "drop2_still_run");
        expect_at(b + 43, exp_out(0, 0, 1, 0, 0), "drop3_pending");
        expect_at(b + 44, exp_out(1, 1, 0, 1, 0), "drop3_lost");
        expect_at(b + 48, exp_out(0, 1, 0, 1, 0), "relock_wait");
        expect_at(b + 56, exp_out(0, 1, 0, 1, 0), "relock_settle");
        expect_at(b + 57, exp_out(0, 0, 1, 1, 0), "relock_run");
        expect_at(b + 59, exp_out(0, 0, 1, 1, 0), "pre_swreq_run");
        expect_at(b + 60, exp_out(1, 1, 0, 1, 0), "swreq_run");
        expect_at(b + 65, exp_out(1, 1, 0, 1, 0), "swreq_restart_hold");
        expect_at(b + 66, exp_out(0, 1, 0, 1, 0), "swreq_restart_wait");
        expect_at(b + 74, exp_out(0, 1, 0, 1, 0), "swreq_settle");
        expect_at(b + 75, exp_out(0, 0, 1, 1, 0), "swreq_run_again");
        wait_cyc(b + 9);
        bus.locked = 1'b1;
        wait_cyc(b + 14);
        bus.locked = 1'b0;
        wait_cyc(b + 15);
        bus.locked = 1'b1;
        wait_cyc(b + 29);
        bus.locked = 1'b0;
        wait_cyc(b + 31);
        bus.locked = 1'b1;
        wait_cyc(b + 39);
        bus.locked = 1'b0;
        wait_cyc(b + 42);
        bus.locked = 1'b1;
        wait_cyc(b + 59);
        bus.sw_req = 1'b1;
        wait_cyc(b + 60);
        bus.sw_req = 1'b0;
        wait_cyc(b + 61);
        bus.sw_req = 1'b1;
        wait_cyc(b + 62);
        bus.sw_req = 1'b0;
        wait_cyc(b + 76);

        // sw_req on the timeout cycle, then async reset in SETTLE.
        do_reset(b);
        expect_at(b,      exp_out(1, 1, 0, 0, 0), "lost_cleared_by_rst");
        expect_at(b + 23, exp_out(0, 1, 0, 0, 0), "tmo_last_wait");
        expect_at(b + 24, exp_out(1, 1, 0, 0, 0), "swreq_vs_timeout");
        expect_at(b + 47, exp_out(0, 1, 0, 0, 0), "tmo2_last_wait");
        expect_at(b + 48, exp_out(1, 1, 0, 0, 1), "tmo2_retry1");
        expect_at(b + 55, exp_out(0, 1, 0, 0, 1), "settle_before_rst");
        expect_at(b + 56, exp_out(1, 1, 0, 0, 0), "async_rst");
        wait_cyc(b + 23);
        bus.sw_req = 1'b1;
        wait_cyc(b + 24);
        bus.sw_req = 1'b0;
        wait_cyc(b + 51);
        bus.locked = 1'b1;
        wait_cyc(b + 56);
        #1;
        rst = 1'b1;
        wait_cyc(b + 58);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d checks left unchecked, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
